// File: rtl/ram_read_scheduler.sv
// Queues RAM-drain jobs (byte counts) and sequences a single RAM block reader,
// one job at a time, reporting each completion in job order.
//
// state    | meaning
// S_IDLE   | waiting for a queued job; pops and latches its counts
// S_LAUNCH | waiting for reader idle; start pulses for one cycle here
// S_WAIT   | reader running; leave when it reports idle again
// S_DONE   | completion offered on the DONE channel until accepted
module ram_read_scheduler #(
    parameter int DW               = 512,
    parameter int CYCLES_PER_BLOCK = 64,
    parameter int QDEPTH           = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] JOB_BYTES,
    input  logic        JOB_VALID,
    output logic        JOB_READY,
    output logic [31:0] full_blocks,
    output logic [7:0]  partial_block_cycles,
    output logic        start,
    input  logic        reader_idle,
    output logic [31:0] DONE_BYTES,
    output logic        DONE_VALID,
    input  logic        DONE_READY,
    output logic        busy,
    output logic [31:0] jobs_completed
);
    localparam int BPC    = DW / 8;
    localparam int BPC_LG = $clog2(BPC);
    localparam int CPB_LG = $clog2(CYCLES_PER_BLOCK);
    localparam int QA     = $clog2(QDEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [31:0]   mem_q [QDEPTH];
    logic [QA-1:0] wr_ptr_q, rd_ptr_q;
    logic [QA:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          start_q, start_d;
    logic [31:0]   job_bytes_q;
    logic [31:0]   full_blocks_q;
    logic [7:0]    partial_q;
    logic [31:0]   jobs_q, jobs_d;

    logic          push, pop;
    logic [31:0]   head;
    logic [32:0]   head_cycles;

    assign JOB_READY = (count_q != (QA+1)'(QDEPTH));
    assign push      = JOB_VALID && JOB_READY;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // 33-bit sum so a 0xFFFFFFFF byte count rounds up without overflow
    assign head_cycles = ({1'b0, head} + 33'(BPC - 1)) >> BPC_LG;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        jobs_d  = jobs_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_cycles == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = reader_idle;
                    end
                end
            end
            S_LAUNCH: begin
                if (start_q) state_d = S_WAIT;
                else         start_d = reader_idle;
            end
            S_WAIT: begin
                if (reader_idle && !start_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (DONE_READY) begin
                    state_d = S_IDLE;
                    jobs_d  = jobs_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= JOB_BYTES;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            job_bytes_q   <= '0;
            full_blocks_q <= '0;
            partial_q     <= '0;
            jobs_q        <= '0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            start_q <= start_d;
            jobs_q  <= jobs_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q      <= rd_ptr_q + 1'b1;
                job_bytes_q   <= head;
                full_blocks_q <= 32'(head_cycles >> CPB_LG);
                partial_q     <= 8'(head_cycles & 33'(CYCLES_PER_BLOCK - 1));
            end
        end
    end

    assign full_blocks          = full_blocks_q;
    assign partial_block_cycles = partial_q;
    assign start                = start_q;
    assign DONE_VALID           = (state_q == S_DONE);
    assign DONE_BYTES           = job_bytes_q;
    assign busy                 = (count_q != '0) || (state_q != S_IDLE);
    assign jobs_completed       = jobs_q;

endmodule

// File: tb/tb_ram_read_scheduler.sv
// Bench for ram_read_scheduler: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based job model.
module tb_ram_read_scheduler;
    localparam int DW  = 512;
    localparam int CPB = 64;
    localparam int QD  = 4;
    localparam int BPC = DW / 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] JOB_BYTES;
    logic        JOB_VALID;
    logic        JOB_READY;
    logic [31:0] full_blocks;
    logic [7:0]  partial_block_cycles;
    logic        start;
    logic        reader_idle;
    logic [31:0] DONE_BYTES;
    logic        DONE_VALID;
    logic        DONE_READY;
    logic        busy;
    logic [31:0] jobs_completed;

    int n_checks = 0;
    int n_errors = 0;

    ram_read_scheduler #(.DW(DW), .CYCLES_PER_BLOCK(CPB), .QDEPTH(QD)) dut (
        .clk(clk), .resetn(resetn),
        .JOB_BYTES(JOB_BYTES), .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
        .full_blocks(full_blocks), .partial_block_cycles(partial_block_cycles),
        .start(start), .reader_idle(reader_idle),
        .DONE_BYTES(DONE_BYTES), .DONE_VALID(DONE_VALID), .DONE_READY(DONE_READY),
        .busy(busy), .jobs_completed(jobs_completed)
    );

    always #5 clk = ~clk;

    // Reader: drops idle while start is high, stays busy a few cycles (or while stalled)
    logic rd_busy = 1'b0;
    logic rd_stall;
    int   rd_cnt = 0;
    assign reader_idle = !rd_busy && !start;

    always @(posedge clk) begin
        if (!resetn) begin
            rd_busy <= 1'b0;
            rd_cnt  <= 0;
        end else if (start) begin
            rd_busy <= 1'b1;
            rd_cnt  <= int'($urandom_range(1, 8));
        end else if (rd_busy && !rd_stall) begin
            if (rd_cnt <= 1) rd_busy <= 1'b0;
            else             rd_cnt  <= rd_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_counts(input logic [31:0] b, output logic [31:0] fb,
                                         output logic [7:0] pb);
        longint unsigned bytes, cyc;
        bytes = {32'd0, b};
        cyc   = (bytes + BPC - 1) / BPC;
        fb    = 32'(cyc / CPB);
        pb    = 8'(cyc % CPB);
    endfunction

    // Model: accepted-but-not-completed jobs in order; at most one launched
    logic [31:0] exp_q[$];
    bit          launched = 0;
    int          model_done = 0;
    logic        prev_dv = 0, prev_dr = 0;
    logic [31:0] prev_db = 0;

    always @(negedge clk) begin
        logic [31:0] efb;
        logic [7:0]  epb;
        if (!resetn) begin
            exp_q.delete();
            launched   = 0;
            model_done = 0;
            prev_dv    = 0;
        end else begin
            chk("jobs_completed", jobs_completed, 64'(model_done));
            chk("busy", busy, 64'(exp_q.size() != 0));
            if (prev_dv && !prev_dr) begin
                chk("done_hold_valid", DONE_VALID, 1);
                chk("done_hold_bytes", DONE_BYTES, prev_db);
            end
            if (start) begin
                chk("start_legal", 64'(exp_q.size() != 0 && !launched && exp_q[0] != 0), 1);
                if (exp_q.size() != 0) begin
                    model_counts(exp_q[0], efb, epb);
                    chk("full_blocks", full_blocks, efb);
                    chk("partial_cycles", partial_block_cycles, epb);
                end
                launched = 1;
            end
            if (DONE_VALID) begin
                chk("done_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("done_bytes", DONE_BYTES, exp_q[0]);
                    chk("done_launch", 64'(launched), 64'(exp_q[0] != 0));
                    if (DONE_READY) begin
                        void'(exp_q.pop_front());
                        model_done++;
                        launched = 0;
                    end
                end
            end
            if (JOB_VALID && JOB_READY) exp_q.push_back(JOB_BYTES);
            prev_dv = DONE_VALID;
            prev_dr = DONE_READY;
            prev_db = DONE_BYTES;
        end
    end

    function automatic logic [31:0] rand_bytes();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return $urandom;
            2, 3:    return 32'($urandom_range(1, 200));
            default: return 32'($urandom_range(1, 20000));
        endcase
    endfunction

    task automatic check_reset_values();
        chk("rst_job_ready", JOB_READY, 1);
        chk("rst_start", start, 0);
        chk("rst_done_valid", DONE_VALID, 0);
        chk("rst_done_bytes", DONE_BYTES, 0);
        chk("rst_full_blocks", full_blocks, 0);
        chk("rst_partial", partial_block_cycles, 0);
        chk("rst_jobs_completed", jobs_completed, 0);
        chk("rst_busy", busy, 0);
    endtask

    // Called and returns just after a rising edge
    task automatic push_job(input logic [31:0] b);
        int n = 0;
        JOB_BYTES = b;
        JOB_VALID = 1'b1;
        @(negedge clk);
        while (!JOB_READY && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("push_accepted", JOB_READY, 1);
        @(posedge clk); #1;
        JOB_VALID = 1'b0;
    endtask

    task automatic wait_done_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!DONE_VALID && n < budget) begin
            n++;
            @(negedge clk);
        end
        chk("done_seen", DONE_VALID, 1);
    endtask

    task automatic run_job(input logic [31:0] b, input logic [31:0] efb,
                           input logic [7:0] epb, input logic [31:0] ejc);
        int n = 0;
        push_job(b);
        @(negedge clk);
        while (!start && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("pop_to_start_cycles", 64'(n), 1);
        chk("lit_full_blocks", full_blocks, efb);
        chk("lit_partial", partial_block_cycles, epb);
        wait_done_valid(100);
        chk("lit_done_bytes", DONE_BYTES, b);
        @(posedge clk); #1;
        chk("lit_jobs_completed", jobs_completed, ejc);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        resetn     = 1'b0;
        JOB_BYTES  = '0;
        JOB_VALID  = 1'b0;
        DONE_READY = 1'b1;
        rd_stall   = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;

        run_job(32'd10000,      32'd2,       8'd29, 32'd1);
        run_job(32'd8192,       32'd2,       8'd0,  32'd2);
        run_job(32'd1,          32'd0,       8'd1,  32'd3);
        run_job(32'hFFFF_FFFF,  32'd1048576, 8'd0,  32'd4);

        // Zero-byte job: DONE one cycle after pop, never a start
        push_job(32'd0);
        @(negedge clk);
        chk("zero_pop_cycle_dv", DONE_VALID, 0);
        @(negedge clk);
        chk("zero_dv", DONE_VALID, 1);
        chk("zero_bytes", DONE_BYTES, 0);
        @(posedge clk); #1;
        chk("zero_jobs_completed", jobs_completed, 5);

        // Stalled reader and blocked DONE: 1 in flight + 4 queued fills the FIFO
        rd_stall   = 1'b1;
        DONE_READY = 1'b0;
        push_job(32'd5000);
        push_job(32'd200);
        push_job(32'd0);
        push_job(32'd9000);
        push_job(32'd3);
        JOB_BYTES = 32'd777;
        JOB_VALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ready_low_when_full", JOB_READY, 0);
        end
        @(posedge clk); #1;
        JOB_VALID = 1'b0;
        rd_stall  = 1'b0;
        wait_done_valid(100);
        repeat (20) begin
            @(negedge clk);
            chk("held_dv", DONE_VALID, 1);
            chk("held_bytes", DONE_BYTES, 32'd5000);
            chk("held_no_start", start, 0);
        end
        @(posedge clk); #1;
        DONE_READY = 1'b1;
        @(posedge clk); #1;
        DONE_READY = 1'b0;
        @(negedge clk);
        chk("pop_cycle_no_start", start, 0);
        @(negedge clk);
        chk("launch_after_accept", start, 1);
        chk("ready_after_pop", JOB_READY, 1);
        @(posedge clk); #1;
        DONE_READY = 1'b1;
        drain(500);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = JOB_VALID && JOB_READY;
            @(posedge clk); #1;
            if (acc || !JOB_VALID) begin
                JOB_VALID = ($urandom_range(0, 2) != 0);
                JOB_BYTES = rand_bytes();
            end
            DONE_READY = ($urandom_range(0, 3) != 0);
        end
        JOB_VALID  = 1'b0;
        DONE_READY = 1'b1;
        drain(2000);

        // Reset while the reader is running abandons the job
        rd_stall = 1'b1;
        push_job(32'd3000);
        begin
            int n = 0;
            @(negedge clk);
            while (!start && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("rst_test_start", start, 1);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_values();
        resetn   = 1'b1;
        rd_stall = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("abandoned_no_done", DONE_VALID, 0);
            chk("abandoned_not_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_read_scheduler.md
Name: ram_read_scheduler

Overview:
- Queues RAM-drain jobs and sequences a single RAM block reader, one job at a time.
- Each job is given as a byte count. The block converts it to full-block and partial-block cycle counts, pulses the reader's start, waits for the reader to go idle, then reports completion.
- Sits between the NIC's transmit control logic and the RAM reader, which streams buffered data out.

Parameters:
- DW, 512, RAM data width in bits; bytes per cycle BPC = DW/8, a power of two.
- CYCLES_PER_BLOCK, 64, data cycles per full RAM block; a power of two, 2..256.
- QDEPTH, 4, job FIFO depth; a power of two, minimum 2.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- JOB_BYTES  in  32  byte count of the job
- JOB_VALID  in  1  job request valid
- JOB_READY  out  1  job accepted when VALID&READY
- full_blocks  out  32  to reader: number of full blocks
- partial_block_cycles  out  8  to reader: cycles in the trailing partial block
- start  out  1  to reader: one-cycle start pulse
- reader_idle  in  1  from reader: high when reader is idle
- DONE_BYTES  out  32  byte count of the completed job
- DONE_VALID  out  1  completion valid
- DONE_READY  in  1  completion accepted when VALID&READY
- busy  out  1  high when the FIFO is non-empty or the FSM is not in S_IDLE
- jobs_completed  out  32  count of completions accepted on the DONE channel

Behaviour:
- Reset: FIFO empty; FSM in S_IDLE.
  - Output reset values: JOB_READY=1, start=0, DONE_VALID=0, DONE_BYTES=0, full_blocks=0, partial_block_cycles=0, jobs_completed=0, busy=0.
  - Reset mid-job abandons the job with no DONE. The reader shares this reset.
- Job FIFO:
  - JOB_READY = !full.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full: the pop frees the slot, but JOB_READY stays low that cycle.
  - Pointers wrap modulo QDEPTH.
- Arithmetic, computed at pop into registers:
  - cycles = (JOB_BYTES + BPC - 1) >> log2(BPC), using 33-bit intermediate width (no overflow at 0xFFFFFFFF).
  - full_blocks = cycles >> log2(CYCLES_PER_BLOCK).
  - partial_block_cycles = cycles & (CYCLES_PER_BLOCK - 1).
  - full_blocks and partial_block_cycles hold their values until the next pop.
- FSM:
  - S_IDLE: if the FIFO is non-empty, pop it, latch job_bytes and the counts, then:
    - if cycles == 0, go to S_DONE;
    - otherwise go to S_LAUNCH.
  - S_LAUNCH: wait for reader_idle=1. In the cycle reader_idle is high, assert start=1 (registered, exactly one cycle) and go to S_WAIT.
  - S_WAIT: entered the cycle after start.
    - The reader deasserts idle during start and keeps it low while busy.
    - Go to S_DONE on the first cycle reader_idle=1, provided start=0 in that cycle.
  - S_DONE: DONE_VALID=1 and DONE_BYTES=job_bytes, held stable until DONE_READY.
    - On acceptance, increment jobs_completed (wraps at 2^32) and go to S_IDLE.
    - A new job is not popped in the acceptance cycle; the earliest pop is the next cycle.
- Latency:
  - Pop to start is 1 cycle when the reader is idle.
  - Reader-idle to DONE_VALID is 1 cycle.
  - A zero-byte job raises DONE_VALID 1 cycle after pop and never pulses start.
- Ordering: completions are reported strictly in job order. There is never more than one job outstanding at the reader.
- DONE_VALID must not depend combinationally on DONE_READY.

Test Plan:
- DW=512, CPB=64, JOB_BYTES=10000 -> full_blocks=2, partial_block_cycles=29; one start pulse; after reader_idle returns -> DONE_BYTES=10000, jobs_completed=1.
- JOB_BYTES=8192 -> full_blocks=2, partial=0. JOB_BYTES=1 -> full_blocks=0, partial=1. JOB_BYTES=0xFFFFFFFF -> full_blocks=1048576, partial=0.
- JOB_BYTES=0 -> start never asserted; DONE_VALID one cycle after pop with DONE_BYTES=0.
- Push 5 jobs back-to-back with QDEPTH=4 and the reader stalled -> JOB_READY low after 4 are queued, reasserts on pop; DONEs arrive in push order with correct byte counts.
- Hold DONE_READY=0 for 20 cycles -> DONE_VALID and DONE_BYTES stable, no further start pulses; release -> next job launches on the following cycle.
- Assert resetn=0 while in S_WAIT -> all outputs return to their reset values next cycle, FIFO empty, no DONE for the abandoned job.
